axi_rd_arbiter: RTL and testbench
=================================

# axi_rd_arbiter

Two-to-one AXI4 read-channel arbiter between the instruction fetch unit (IFU) and the load/store unit (LSU), driving the read half of the core's `io_master` AXI4 port. It allows one outstanding burst at a time, with round-robin grant. AR is registered toward the bus. R is steered combinationally back to the granted requester. The write channels are LSU-exclusive and are wired directly at the top level, outside this block.

## Interface
Parameters:
- `IFU_ID`, default 4'h0: ARID driven for IFU bursts.
- `LSU_ID`, default 4'h1: ARID driven for LSU bursts.
- `AW`, default `` `CPU_WIDTH ``: address width.
- `DW`, default `` `CPU_WIDTH ``: data width.

Ports (`x` = `ifu` or `lsu`, one identical set per requester):
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `x_arvalid` / `x_arready`  in / out  1  requester AR handshake.
- `x_araddr`  in  AW  burst address.
- `x_arlen`  in  8  beats minus 1.
- `x_arsize`  in  3  AXI size.
- `x_arburst`  in  2  AXI burst type.
- `x_rvalid` / `x_rready`  out / in  1  requester R handshake.
- `x_rdata`  out  DW  read data.
- `x_rresp`  out  2  response.
- `x_rlast`  out  1  last beat.
- `m_arvalid` / `m_arready`  out / in  1  bus AR handshake.
- `m_araddr`  out  AW  bus address.
- `m_arid`  out  4  bus ARID.
- `m_arlen`  out  8  bus burst length.
- `m_arsize`  out  3  bus size.
- `m_arburst`  out  2  bus burst type.
- `m_rvalid` / `m_rready`  in / out  1  bus R handshake.
- `m_rdata`  in  DW  bus read data.
- `m_rresp`  in  2  bus response.
- `m_rlast`  in  1  bus last beat.
- `m_rid`  in  4  bus RID.
- `proto_err`  out  1  sticky protocol error flag; cleared only by reset.

## Operation
- FSM states are IDLE, ADDR, DATA. The grant register `gnt` is 0 for IFU and 1 for LSU. The round-robin pointer `rr` holds the preferred requester.
- **IDLE.** If exactly one `x_arvalid` is high, grant that requester. If both are high, grant `rr`.
  - In the same cycle, pulse `x_arready` of the winner.
  - Latch `araddr`/`arlen`/`arsize`/`arburst` into the AR registers.
  - Latch `arid` as IFU_ID or LSU_ID.
  - Load the beat counter `beat <= 0` and go to ADDR.
- **ADDR.** `m_arvalid = 1` with the latched fields held stable. On `m_arready`, go to DATA.
- **DATA.** R is steered to the granted requester only:
  - `m_rready = x_rready[gnt]`.
  - `x_rvalid[gnt] = m_rvalid`.
  - `x_rdata`, `x_rresp` and `x_rlast` of the granted requester follow `m_rdata`, `m_rresp` and `m_rlast`.
  - The non-granted requester has `x_rvalid = 0`.
- **Each R handshake:** `beat <= beat + 1` (8-bit, no wrap in legal traffic).
- **Handshake with `m_rlast = 1`:** go to IDLE and set `rr <= ~gnt`.
- **Error checks** (each sets `proto_err`; the burst still completes normally):
  - `m_rvalid` in DATA with `m_rid != arid`.
  - `m_rlast = 1` while `beat != arlen`.
  - `beat == arlen` handshake with `m_rlast = 0`. The FSM still waits for `rlast`.
- `m_rvalid` outside DATA sets `proto_err`. It is not acknowledged (`m_rready = 0`).
- A requester dropping `x_arvalid` before grant is tolerated; its request is simply not granted.

## Timing
- **Reset values:**
  - State IDLE, `gnt = 0`, `rr = 0` (IFU preferred).
  - `m_arvalid = 0`, all `x_arready = 0`, all `x_rvalid = 0`, `m_rready = 0`.
  - `proto_err = 0`, AR registers 0.
- **Async reset mid-burst:** all outputs return to reset values immediately. The outstanding burst is abandoned.
- **Grant latency:** `x_arready` is high in the first IDLE cycle with a valid request. `m_arvalid` rises the next cycle.
- **Minimum spacing:** back-to-back bursts need 1 IDLE cycle between the last R beat and the next `x_arready`.
- **AR stability:** `m_arvalid` is held, with fields stable, until `m_arready`. There is no combinational path from `m_arready` to `x_arready`.
- **R latency:** R is zero-latency combinational in DATA. The path `m_rvalid`→`x_rvalid` and `x_rready`→`m_rready` is combinational.
- **Simultaneous requests** alternate strictly: IFU, LSU, IFU, …

## Structure
- Shared package/defines (`defines.vh`):
  - `` `CPU_WIDTH ``.
  - State encodings `ARB_IDLE`, `ARB_ADDR`, `ARB_DATA`.
  - AXI response constants `AXI_OKAY`, `AXI_SLVERR`.
- One natural sub-module: `rr_arb2`. It is a 2-way round-robin pick with inputs `req[1:0]` and `rr`, and output `gnt`, and is purely combinational. The pointer update stays in the parent.

## Test plan
1. **IFU only:**
   - Stimulus: IFU requests addr 0x8000_0000, `arlen` 0.
   - Required: `ifu_arready` pulses, then `m_arvalid` with `m_arid` 0.
   - Bus returns `rdata` 0x1234_5678 with `rlast` → IFU sees it, LSU `rvalid` stays 0.
2. **Simultaneous requests after reset:**
   - Stimulus: IFU and LSU request in the same cycle.
   - Required: IFU is granted first, LSU next.
   - Stimulus: both request again. Required: IFU is granted (alternation is confirmed).
3. **Burst with backpressure:**
   - Stimulus: LSU burst with `arlen` 3; `m_arready` held low for 5 cycles; `lsu_rready` toggled.
   - Required: AR fields stay stable, exactly 4 beats are delivered, and `proto_err` stays 0.
4. **Bad RID:**
   - Stimulus: return `m_rid` 0x5 for an IFU burst.
   - Required: `proto_err` = 1 and the burst still completes.
5. **Early `rlast`:**
   - Stimulus: `arlen` 3 with `m_rlast` on beat 1.
   - Required: `proto_err` = 1 and the FSM returns to IDLE.
6. **Reset mid-DATA:**
   - Stimulus: `reset` asserted low.
   - Required: all outputs are 0 asynchronously; after release, a new IFU request is granted normally.

Source files
------------

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the two-requester AXI4 read arbiter.
// Holds the CPU data/address width, FSM state encodings and AXI response codes.
package axi_rd_arbiter_pkg;

    localparam int CPU_WIDTH = 32;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_t;

    localparam logic [1:0] AXI_OKAY   = 2'b00;
    localparam logic [1:0] AXI_SLVERR = 2'b10;

endpackage

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins outright; on a tie the
// pointer decides. Purely combinational, the pointer itself lives in the parent.
module axi_rd_arbiter_rr_arb2 (
    input  logic [1:0] req,
    input  logic       rr,
    output logic       gnt
);

    assign gnt = (req == 2'b11) ? rr : req[1];

endmodule

// File: rtl/axi_rd_arbiter.sv
// IFU/LSU read-channel arbiter onto a single AXI4 master: one burst in flight,
// round-robin on simultaneous requests, registered AR and combinational R steering.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter logic [3:0] IFU_ID = 4'h0,
    parameter logic [3:0] LSU_ID = 4'h1,
    parameter int         AW     = CPU_WIDTH,
    parameter int         DW     = CPU_WIDTH
) (
    input  logic          clock,
    input  logic          reset,

    input  logic          ifu_arvalid,
    output logic          ifu_arready,
    input  logic [AW-1:0] ifu_araddr,
    input  logic [7:0]    ifu_arlen,
    input  logic [2:0]    ifu_arsize,
    input  logic [1:0]    ifu_arburst,
    output logic          ifu_rvalid,
    input  logic          ifu_rready,
    output logic [DW-1:0] ifu_rdata,
    output logic [1:0]    ifu_rresp,
    output logic          ifu_rlast,

    input  logic          lsu_arvalid,
    output logic          lsu_arready,
    input  logic [AW-1:0] lsu_araddr,
    input  logic [7:0]    lsu_arlen,
    input  logic [2:0]    lsu_arsize,
    input  logic [1:0]    lsu_arburst,
    output logic          lsu_rvalid,
    input  logic          lsu_rready,
    output logic [DW-1:0] lsu_rdata,
    output logic [1:0]    lsu_rresp,
    output logic          lsu_rlast,

    output logic          m_arvalid,
    input  logic          m_arready,
    output logic [AW-1:0] m_araddr,
    output logic [3:0]    m_arid,
    output logic [7:0]    m_arlen,
    output logic [2:0]    m_arsize,
    output logic [1:0]    m_arburst,
    input  logic          m_rvalid,
    output logic          m_rready,
    input  logic [DW-1:0] m_rdata,
    input  logic [1:0]    m_rresp,
    input  logic          m_rlast,
    input  logic [3:0]    m_rid,

    output logic          proto_err
);

    arb_state_t    state;
    logic          gnt;
    logic          rr;
    logic          arvalid_q;
    logic [AW-1:0] araddr_q;
    logic [3:0]    arid_q;
    logic [7:0]    arlen_q;
    logic [2:0]    arsize_q;
    logic [1:0]    arburst_q;
    logic [7:0]    beat;
    logic          err_q;

    logic          pick;
    logic          grant_fire;
    logic          in_data;
    logic          r_fire;
    logic          err_set;

    axi_rd_arbiter_rr_arb2 u_rr_arb2 (
        .req ({lsu_arvalid, ifu_arvalid}),
        .rr  (rr),
        .gnt (pick)
    );

    // The reset term keeps arready low while reset is held, even if a requester is valid.
    assign grant_fire  = (state == ARB_IDLE) && (ifu_arvalid || lsu_arvalid) && reset;
    assign ifu_arready = grant_fire && !pick;
    assign lsu_arready = grant_fire && pick;

    assign in_data  = (state == ARB_DATA);
    assign m_rready = in_data && (gnt ? lsu_rready : ifu_rready);
    assign r_fire   = m_rvalid && m_rready;

    assign ifu_rvalid = in_data && !gnt && m_rvalid;
    assign ifu_rdata  = (in_data && !gnt) ? m_rdata : '0;
    assign ifu_rresp  = (in_data && !gnt) ? m_rresp : AXI_OKAY;
    assign ifu_rlast  = in_data && !gnt && m_rlast;

    assign lsu_rvalid = in_data && gnt && m_rvalid;
    assign lsu_rdata  = (in_data && gnt) ? m_rdata : '0;
    assign lsu_rresp  = (in_data && gnt) ? m_rresp : AXI_OKAY;
    assign lsu_rlast  = in_data && gnt && m_rlast;

    assign err_set = (m_rvalid && !in_data)
                  || (in_data && m_rvalid && (m_rid != arid_q))
                  || (r_fire && m_rlast && (beat != arlen_q))
                  || (r_fire && !m_rlast && (beat == arlen_q));

    assign m_arvalid = arvalid_q;
    assign m_araddr  = araddr_q;
    assign m_arid    = arid_q;
    assign m_arlen   = arlen_q;
    assign m_arsize  = arsize_q;
    assign m_arburst = arburst_q;
    assign proto_err = err_q;

    // Burst FSM: latch the winner's AR fields, hold them until accepted, then
    // count R beats until rlast and hand preference to the other requester.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ARB_IDLE;
            gnt       <= 1'b0;
            rr        <= 1'b0;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arid_q    <= 4'h0;
            arlen_q   <= 8'h00;
            arsize_q  <= 3'h0;
            arburst_q <= 2'h0;
            beat      <= 8'h00;
            err_q     <= 1'b0;
        end else begin
            if (err_set) begin
                err_q <= 1'b1;
            end
            case (state)
                ARB_IDLE: begin
                    if (grant_fire) begin
                        gnt       <= pick;
                        araddr_q  <= pick ? lsu_araddr  : ifu_araddr;
                        arlen_q   <= pick ? lsu_arlen   : ifu_arlen;
                        arsize_q  <= pick ? lsu_arsize  : ifu_arsize;
                        arburst_q <= pick ? lsu_arburst : ifu_arburst;
                        arid_q    <= pick ? LSU_ID      : IFU_ID;
                        beat      <= 8'h00;
                        arvalid_q <= 1'b1;
                        state     <= ARB_ADDR;
                    end
                end
                ARB_ADDR: begin
                    if (m_arready) begin
                        arvalid_q <= 1'b0;
                        state     <= ARB_DATA;
                    end
                end
                ARB_DATA: begin
                    if (r_fire) begin
                        beat <= beat + 8'd1;
                        if (m_rlast) begin
                            rr    <= !gnt;
                            state <= ARB_IDLE;
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: single and simultaneous requests, AR
// backpressure, protocol-error cases and asynchronous reset mid-burst.
module tb_axi_rd_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;

    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready, ifu_rlast;
    logic [31:0] ifu_araddr, ifu_rdata;
    logic [7:0]  ifu_arlen;
    logic [2:0]  ifu_arsize;
    logic [1:0]  ifu_arburst, ifu_rresp;

    logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready, lsu_rlast;
    logic [31:0] lsu_araddr, lsu_rdata;
    logic [7:0]  lsu_arlen;
    logic [2:0]  lsu_arsize;
    logic [1:0]  lsu_arburst, lsu_rresp;

    logic        m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
    logic [31:0] m_araddr, m_rdata;
    logic [3:0]  m_arid, m_rid;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst, m_rresp;
    logic        proto_err;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    axi_rd_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .ifu_arvalid (ifu_arvalid),
        .ifu_arready (ifu_arready),
        .ifu_araddr  (ifu_araddr),
        .ifu_arlen   (ifu_arlen),
        .ifu_arsize  (ifu_arsize),
        .ifu_arburst (ifu_arburst),
        .ifu_rvalid  (ifu_rvalid),
        .ifu_rready  (ifu_rready),
        .ifu_rdata   (ifu_rdata),
        .ifu_rresp   (ifu_rresp),
        .ifu_rlast   (ifu_rlast),
        .lsu_arvalid (lsu_arvalid),
        .lsu_arready (lsu_arready),
        .lsu_araddr  (lsu_araddr),
        .lsu_arlen   (lsu_arlen),
        .lsu_arsize  (lsu_arsize),
        .lsu_arburst (lsu_arburst),
        .lsu_rvalid  (lsu_rvalid),
        .lsu_rready  (lsu_rready),
        .lsu_rdata   (lsu_rdata),
        .lsu_rresp   (lsu_rresp),
        .lsu_rlast   (lsu_rlast),
        .m_arvalid   (m_arvalid),
        .m_arready   (m_arready),
        .m_araddr    (m_araddr),
        .m_arid      (m_arid),
        .m_arlen     (m_arlen),
        .m_arsize    (m_arsize),
        .m_arburst   (m_arburst),
        .m_rvalid    (m_rvalid),
        .m_rready    (m_rready),
        .m_rdata     (m_rdata),
        .m_rresp     (m_rresp),
        .m_rlast     (m_rlast),
        .m_rid       (m_rid),
        .proto_err   (proto_err)
    );

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        ifu_arvalid = 1'b0; ifu_araddr = '0; ifu_arlen = '0; ifu_arsize = '0; ifu_arburst = '0;
        ifu_rready  = 1'b0;
        lsu_arvalid = 1'b0; lsu_araddr = '0; lsu_arlen = '0; lsu_arsize = '0; lsu_arburst = '0;
        lsu_rready  = 1'b0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rid = '0;
    endtask

    task automatic req_ifu(input logic [31:0] addr, input logic [7:0] len);
        ifu_arvalid = 1'b1; ifu_araddr = addr; ifu_arlen = len; ifu_arsize = 3'd2; ifu_arburst = 2'd1;
    endtask

    task automatic req_lsu(input logic [31:0] addr, input logic [7:0] len);
        lsu_arvalid = 1'b1; lsu_araddr = addr; lsu_arlen = len; lsu_arsize = 3'd2; lsu_arburst = 2'd1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        idle_inputs();
        reset = 1'b0;
        #1;
        check_bit("rst_proto_err", proto_err, 1'b0);
        check_bit("rst_m_arvalid", m_arvalid, 1'b0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Entered on a negedge with the request(s) already driven; leaves the DUT in DATA.
    task automatic grant_burst(input logic who, input logic [31:0] addr, input logic [7:0] len);
        #1;
        check_bit("arready_win", who ? lsu_arready : ifu_arready, 1'b1);
        check_bit("arready_lose", who ? ifu_arready : lsu_arready, 1'b0);
        check_bit("arvalid_pre", m_arvalid, 1'b0);
        @(negedge clock);
        if (who) lsu_arvalid = 1'b0; else ifu_arvalid = 1'b0;
        m_arready = 1'b1;
        #1;
        check_bit("arready_in_addr", ifu_arready | lsu_arready, 1'b0);
        check_bit("m_arvalid", m_arvalid, 1'b1);
        check_word("m_arid", 64'(m_arid), who ? 64'h1 : 64'h0);
        check_word("m_araddr", 64'(m_araddr), 64'(addr));
        check_word("m_arlen", 64'(m_arlen), 64'(len));
        check_word("m_arsize", 64'(m_arsize), 64'h2);
        check_word("m_arburst", 64'(m_arburst), 64'h1);
        @(negedge clock);
        m_arready = 1'b0;
    endtask

    task automatic serve_beats(input logic who, input logic [3:0] rid, input int n, input int last_at,
                               input logic [31:0] base, input logic [1:0] resp);
        for (int i = 0; i < n; i++) begin
            m_rvalid = 1'b1; m_rid = rid; m_rdata = base + 32'(i); m_rresp = resp;
            m_rlast  = (i == last_at);
            if (who) lsu_rready = 1'b1; else ifu_rready = 1'b1;
            #1;
            check_bit("rvalid_gnt", who ? lsu_rvalid : ifu_rvalid, 1'b1);
            check_bit("rvalid_other", who ? ifu_rvalid : lsu_rvalid, 1'b0);
            check_bit("m_rready", m_rready, 1'b1);
            check_word("rdata", 64'(who ? lsu_rdata : ifu_rdata), 64'(base + 32'(i)));
            check_word("rresp", 64'(who ? lsu_rresp : ifu_rresp), 64'(resp));
            check_bit("rlast", who ? lsu_rlast : ifu_rlast, (i == last_at));
            @(negedge clock);
        end
        m_rvalid = 1'b0; m_rlast = 1'b0; ifu_rready = 1'b0; lsu_rready = 1'b0;
    endtask

    initial begin
        int   got;
        logic rdy;

        idle_inputs();
        reset = 1'b0;
        #1;
        check_bit("reset_ifu_arready", ifu_arready, 1'b0);
        check_bit("reset_m_arvalid", m_arvalid, 1'b0);
        check_bit("reset_m_rready", m_rready, 1'b0);
        check_bit("reset_proto_err", proto_err, 1'b0);
        check_word("reset_m_araddr", 64'(m_araddr), 64'h0);
        @(negedge clock);
        reset = 1'b1;

        $display("[TB] IFU-only single beat");
        @(negedge clock);
        req_ifu(32'h8000_0000, 8'd0);
        grant_burst(1'b0, 32'h8000_0000, 8'd0);
        serve_beats(1'b0, 4'h0, 1, 0, 32'h1234_5678, 2'b10);
        #1;
        check_bit("t1_proto_err", proto_err, 1'b0);
        check_bit("t1_idle_arvalid", m_arvalid, 1'b0);

        $display("[TB] simultaneous requests alternate");
        do_reset();
        req_ifu(32'h0000_1000, 8'd0);
        req_lsu(32'h0000_2000, 8'd0);
        grant_burst(1'b0, 32'h0000_1000, 8'd0);
        serve_beats(1'b0, 4'h0, 1, 0, 32'hA000_0000, 2'b00);
        grant_burst(1'b1, 32'h0000_2000, 8'd0);
        serve_beats(1'b1, 4'h1, 1, 0, 32'hB000_0000, 2'b00);
        req_ifu(32'h0000_1100, 8'd0);
        req_lsu(32'h0000_2100, 8'd0);
        grant_burst(1'b0, 32'h0000_1100, 8'd0);
        serve_beats(1'b0, 4'h0, 1, 0, 32'hA100_0000, 2'b00);
        grant_burst(1'b1, 32'h0000_2100, 8'd0);
        serve_beats(1'b1, 4'h1, 1, 0, 32'hB100_0000, 2'b00);

        $display("[TB] LSU burst with AR and R backpressure");
        req_lsu(32'h0000_3000, 8'd3);
        #1;
        check_bit("t3_lsu_arready", lsu_arready, 1'b1);
        @(negedge clock);
        lsu_arvalid = 1'b0;
        lsu_araddr  = 32'hDEAD_BEEF;
        lsu_arlen   = 8'd9;
        for (int c = 0; c < 5; c++) begin
            #1;
            check_bit("t3_arvalid_held", m_arvalid, 1'b1);
            check_word("t3_araddr_held", 64'(m_araddr), 64'h3000);
            check_word("t3_arlen_held", 64'(m_arlen), 64'h3);
            @(negedge clock);
        end
        m_arready = 1'b1;
        @(negedge clock);
        m_arready = 1'b0;
        got = 0;
        for (int c = 0; c < 16 && got < 4; c++) begin
            rdy = (c % 2 == 1);
            m_rvalid = 1'b1; m_rid = 4'h1; m_rresp = 2'b00;
            m_rdata  = 32'hC000_0000 + 32'(got);
            m_rlast  = (got == 3);
            lsu_rready = rdy;
            #1;
            check_bit("t3_lsu_rvalid", lsu_rvalid, 1'b1);
            check_bit("t3_m_rready", m_rready, rdy);
            if (lsu_rvalid && lsu_rready) begin
                check_word("t3_rdata", 64'(lsu_rdata), 64'(32'hC000_0000 + 32'(got)));
                got++;
            end
            @(negedge clock);
        end
        m_rvalid = 1'b0; m_rlast = 1'b0; lsu_rready = 1'b0;
        #1;
        check_word("t3_beats", 64'(got), 64'd4);
        check_bit("t3_proto_err", proto_err, 1'b0);

        $display("[TB] bad RID");
        @(negedge clock);
        req_ifu(32'h0000_4000, 8'd0);
        grant_burst(1'b0, 32'h0000_4000, 8'd0);
        serve_beats(1'b0, 4'h5, 1, 0, 32'hD000_0000, 2'b00);
        #1;
        check_bit("t4_proto_err", proto_err, 1'b1);
        req_ifu(32'h0000_4100, 8'd0);
        grant_burst(1'b0, 32'h0000_4100, 8'd0);
        serve_beats(1'b0, 4'h0, 1, 0, 32'hD100_0000, 2'b00);
        #1;
        check_bit("t4_sticky", proto_err, 1'b1);
        do_reset();

        $display("[TB] early rlast");
        req_ifu(32'h0000_5000, 8'd3);
        grant_burst(1'b0, 32'h0000_5000, 8'd3);
        serve_beats(1'b0, 4'h0, 2, 1, 32'hE000_0000, 2'b00);
        #1;
        check_bit("t5_proto_err", proto_err, 1'b1);

        $display("[TB] reset during DATA");
        req_ifu(32'h0000_6000, 8'd0);
        grant_burst(1'b0, 32'h0000_6000, 8'd0);
        ifu_arvalid = 1'b1;
        m_rvalid = 1'b1; m_rid = 4'h0; m_rdata = 32'hF00D_0000; ifu_rready = 1'b1;
        #1;
        check_bit("t6_pre_rvalid", ifu_rvalid, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check_bit("t6_ifu_rvalid", ifu_rvalid, 1'b0);
        check_bit("t6_m_rready", m_rready, 1'b0);
        check_bit("t6_m_arvalid", m_arvalid, 1'b0);
        check_bit("t6_ifu_arready", ifu_arready, 1'b0);
        check_bit("t6_proto_err", proto_err, 1'b0);
        check_word("t6_ifu_rdata", 64'(ifu_rdata), 64'h0);
        check_word("t6_m_araddr", 64'(m_araddr), 64'h0);
        @(negedge clock);
        idle_inputs();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        req_ifu(32'h0000_7000, 8'd0);
        grant_burst(1'b0, 32'h0000_7000, 8'd0);
        serve_beats(1'b0, 4'h0, 1, 0, 32'h7777_0000, 2'b00);
        #1;
        check_bit("t6_after_proto_err", proto_err, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
